// File: rtl/pipeline_types.sv
// ---------------------------------------------------------------------------
// pipeline_types
// Shared types for the WS2812 receive pipeline.
//   shift_reg_input_t : control bundle from the bit sequencer to shift_register
//   seq_state_t       : bit sequencer state encoding (3 bits)
//   C_T_*_CYC         : default pulse timing in i_clk cycles (50 MHz clock)
//   sat_inc16         : saturating 16-bit increment
// ---------------------------------------------------------------------------
package pipeline_types;

  typedef struct packed {
    logic shift_en;    // one-cycle strobe: shift decode_bit into the register
    logic decode_bit;  // decoded bit value, held between strobes
    logic treset;      // one-cycle frame-end (latch) strobe
  } shift_reg_input_t;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    HIGH      = 3'd2,
    LOW       = 3'd3,
    STUCK     = 3'd4
  } seq_state_t;

  // Defaults for a 50 MHz clock: T0H ~20 cycles, T1H ~40 cycles, reset 50 us.
  localparam int unsigned C_T_MIN_CYC   = 5;
  localparam int unsigned C_T_ONE_CYC   = 30;
  localparam int unsigned C_T_RESET_CYC = 2500;

  localparam shift_reg_input_t C_SHIFT_REG_IDLE = '{
    shift_en:   1'b0,
    decode_bit: 1'b0,
    treset:     1'b0
  };

  // Saturating increment used for the per-frame bit counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ws2812_sync_edge.sv
// ---------------------------------------------------------------------------
// ws2812_sync_edge
// Brings an asynchronous serial line into the i_clk domain with a 2-flop
// synchronizer and detects edges with one extra history flop.
//   i_clk     : sampling clock
//   i_reset_n : asynchronous active-low reset (all flops clear to 0)
//   i_din     : asynchronous input line
//   o_level   : synchronized level (second synchronizer flop)
//   o_rise    : one-cycle strobe, synchronized level went 0 -> 1
//   o_fall    : one-cycle strobe, synchronized level went 1 -> 0
// ---------------------------------------------------------------------------
module ws2812_sync_edge (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_din,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchronizer chain plus history flop for edge detection.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= i_din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign o_level = s2_q;
  assign o_rise  = s2_q & ~s3_q;
  assign o_fall  = ~s2_q & s3_q;

endmodule

// File: rtl/ws2812_bit_sequencer.sv
// ---------------------------------------------------------------------------
// ws2812_bit_sequencer
// Measures each high pulse on the WS2812 serial line, decodes it as 0/1 and
// drives the shift_register controls. Short pulses are rejected as glitches,
// a line held high is flagged as stuck, and a long low time ends the frame.
//   i_clk          : system clock
//   i_reset_n      : asynchronous active-low reset
//   i_din          : raw serial input (asynchronous to i_clk)
//   o_shift_reg    : shift_en / decode_bit / treset to shift_register
//   o_bit_count    : bits accepted since the last treset (saturating)
//   o_frame_active : high from the first accepted bit until treset
//   o_err_glitch   : one-cycle pulse, high pulse shorter than T_MIN_CYC
//   o_err_stuck    : one-cycle pulse, line high for T_RESET_CYC cycles
// All outputs are registered.
// ---------------------------------------------------------------------------
module ws2812_bit_sequencer
  import pipeline_types::*;
#(
  parameter int unsigned T_MIN_CYC   = C_T_MIN_CYC,
  parameter int unsigned T_ONE_CYC   = C_T_ONE_CYC,
  parameter int unsigned T_RESET_CYC = C_T_RESET_CYC,
  parameter int unsigned CNT_W       = 12
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_din,
  output shift_reg_input_t o_shift_reg,
  output logic [15:0]      o_bit_count,
  output logic             o_frame_active,
  output logic             o_err_glitch,
  output logic             o_err_stuck
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(T_MIN_CYC);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(T_ONE_CYC);
  localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(T_RESET_CYC);

  logic level_s;
  logic rise_s;
  logic fall_s;

  seq_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_plus1;
  shift_reg_input_t shift_reg_q;
  logic [15:0]      bit_count_q;
  logic             frame_active_q;
  logic             err_glitch_q;
  logic             err_stuck_q;

  ws2812_sync_edge u_sync_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_din     (i_din),
    .o_level   (level_s),
    .o_rise    (rise_s),
    .o_fall    (fall_s)
  );

  // The pulse counter never wraps, so a runaway line cannot alias to a
  // short pulse width.
  assign cnt_plus1 = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  // Sequencer FSM: state, pulse counter and all registered outputs.
  // Strobes default low every cycle; decode_bit holds between shifts.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= WAIT_IDLE;
      cnt_q          <= CNT_ZERO;
      shift_reg_q    <= C_SHIFT_REG_IDLE;
      bit_count_q    <= 16'd0;
      frame_active_q <= 1'b0;
      err_glitch_q   <= 1'b0;
      err_stuck_q    <= 1'b0;
    end else begin
      shift_reg_q.shift_en <= 1'b0;
      shift_reg_q.treset   <= 1'b0;
      err_glitch_q         <= 1'b0;
      err_stuck_q          <= 1'b0;

      case (state_q)
        // After reset we may be mid-frame: only a full reset-length low
        // period re-aligns us to a bit boundary, so edges are ignored here.
        WAIT_IDLE: begin
          if (cnt_q == RESET_CNT) begin
            shift_reg_q.treset <= 1'b1;
            bit_count_q        <= 16'd0;
            frame_active_q     <= 1'b0;
            cnt_q              <= CNT_ZERO;
            state_q            <= IDLE;
          end else if (level_s) begin
            cnt_q <= CNT_ZERO;
          end else begin
            cnt_q <= cnt_plus1;
          end
        end

        IDLE: begin
          if (rise_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= HIGH;
          end
        end

        // cnt counts synchronized high cycles; the rise cycle is the first.
        HIGH: begin
          if (fall_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= LOW;
            if (cnt_q < MIN_CNT) begin
              err_glitch_q <= 1'b1;
            end else begin
              shift_reg_q.shift_en   <= 1'b1;
              shift_reg_q.decode_bit <= (cnt_q >= ONE_CNT);
              bit_count_q            <= sat_inc16(bit_count_q);
              frame_active_q         <= 1'b1;
            end
          end else if (cnt_q == RESET_CNT) begin
            err_stuck_q <= 1'b1;
            state_q     <= STUCK;
          end else begin
            cnt_q <= cnt_plus1;
          end
        end

        // Frame end has priority over a rise landing on the same cycle;
        // that rise is dropped and the sequencer waits in IDLE.
        LOW: begin
          if (cnt_q == RESET_CNT) begin
            shift_reg_q.treset <= 1'b1;
            bit_count_q        <= 16'd0;
            frame_active_q     <= 1'b0;
            cnt_q              <= CNT_ZERO;
            state_q            <= IDLE;
          end else if (rise_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_plus1;
          end
        end

        // The stuck pulse is not a bit; the eventual fall only restarts
        // the low-time measurement.
        STUCK: begin
          if (fall_s) begin
            cnt_q   <= CNT_ONE;
            state_q <= LOW;
          end
        end

        default: begin
          state_q <= WAIT_IDLE;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign o_shift_reg    = shift_reg_q;
  assign o_bit_count    = bit_count_q;
  assign o_frame_active = frame_active_q;
  assign o_err_glitch   = err_glitch_q;
  assign o_err_stuck    = err_stuck_q;

endmodule

// File: tb/tb_ws2812_bit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ws2812_bit_sequencer
// Self-checking bench: expected sequencer events are queued as pulses are
// driven and matched in order by a monitor watching the DUT strobes.
// ---------------------------------------------------------------------------
module tb_ws2812_bit_sequencer;
  import pipeline_types::*;

  typedef enum int {
    EV_NONE   = 0,
    EV_SHIFT0 = 1,
    EV_SHIFT1 = 2,
    EV_GLITCH = 3,
    EV_STUCK  = 4,
    EV_TRESET = 5
  } ev_t;

  typedef struct {
    int  high;
    int  low;
    ev_t exp;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             din;
  shift_reg_input_t sr;
  logic [15:0]      bit_count;
  logic             frame_active;
  logic             err_glitch;
  logic             err_stuck;

  int   checks;
  int   passes;
  ev_t  sb[$];
  int   exp_count;
  logic last_bit;
  ev_t  mon_ev;
  int   mon_n;

  ws2812_bit_sequencer dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_din          (din),
    .o_shift_reg    (sr),
    .o_bit_count    (bit_count),
    .o_frame_active (frame_active),
    .o_err_glitch   (err_glitch),
    .o_err_stuck    (err_stuck)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input ev_t e);
    sb.push_back(e);
    if (e == EV_SHIFT0 || e == EV_SHIFT1) begin
      exp_count++;
      last_bit = (e == EV_SHIFT1);
    end
  endtask

  // Called at a falling clock edge; leaves at a falling clock edge.
  task automatic send_pulse(input int high, input int low);
    din = 1'b1;
    repeat (high) @(negedge clk);
    din = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  // Waits (bounded) for treset; returns the number of falling edges waited.
  task automatic wait_treset(input string name, input int budget, output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sr.treset) begin
        found = 1'b1;
        cyc = i + 1;
        break;
      end
    end
    chk(name, int'(found), 1);
    exp_count = 0;
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      mon_n = int'(sr.shift_en) + int'(sr.treset) + int'(err_glitch) + int'(err_stuck);
      if (mon_n > 1) begin
        chk("strobe_exclusive", mon_n, 1);
      end
      if (mon_n >= 1) begin
        if (sr.shift_en) mon_ev = sr.decode_bit ? EV_SHIFT1 : EV_SHIFT0;
        else if (err_glitch) mon_ev = EV_GLITCH;
        else if (err_stuck) mon_ev = EV_STUCK;
        else mon_ev = EV_TRESET;
        if (sb.size() == 0) begin
          chk("unexpected_event", int'(mon_ev), int'(EV_NONE));
        end else begin
          chk("event", int'(mon_ev), int'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    vec_t        vecs[6];
    logic [23:0] pattern;
    int          cyc;
    logic        b;

    vecs[0] = '{high: 4,  low: 40, exp: EV_GLITCH};
    vecs[1] = '{high: 5,  low: 40, exp: EV_SHIFT0};
    vecs[2] = '{high: 29, low: 40, exp: EV_SHIFT0};
    vecs[3] = '{high: 30, low: 40, exp: EV_SHIFT1};
    vecs[4] = '{high: 20, low: 42, exp: EV_SHIFT0};
    vecs[5] = '{high: 40, low: 22, exp: EV_SHIFT1};

    checks    = 0;
    passes    = 0;
    exp_count = 0;
    last_bit  = 1'b0;
    rst_n     = 1'b0;
    din       = 1'b1;

    // Reset values, then release with the line high (mid-frame resync).
    repeat (5) @(negedge clk);
    chk("reset_shift_reg", int'(sr), 0);
    chk("reset_bit_count", int'(bit_count), 0);
    chk("reset_frame_active", int'(frame_active), 0);
    chk("reset_err_glitch", int'(err_glitch), 0);
    chk("reset_err_stuck", int'(err_stuck), 0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    push(EV_TRESET);
    din = 1'b0;
    wait_treset("resync_treset", 3000, cyc);
    chk_range("resync_latency", cyc, 2501, 2505);
    chk("resync_bit_count", int'(bit_count), 0);
    chk("resync_frame_active", int'(frame_active), 0);

    // 24-bit frame 0xA5C3F0, MSB first, 62-cycle bit period.
    pattern = 24'hA5C3F0;
    for (int i = 23; i >= 0; i--) begin
      b = pattern[i];
      push(b ? EV_SHIFT1 : EV_SHIFT0);
      send_pulse(b ? 40 : 20, b ? 22 : 42);
    end
    chk("frame_bit_count", int'(bit_count), 24);
    chk("frame_active", int'(frame_active), 1);
    chk("frame_queue_drained", sb.size(), 0);
    push(EV_TRESET);
    wait_treset("frame_treset", 3000, cyc);
    chk("frame_count_cleared", int'(bit_count), 0);
    chk("frame_active_cleared", int'(frame_active), 0);
    chk("decode_bit_hold", int'(sr.decode_bit), int'(last_bit));

    // Threshold table.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].exp);
      send_pulse(vecs[i].high, vecs[i].low);
    end
    chk("thresh_bit_count", int'(bit_count), exp_count);
    chk("thresh_queue_drained", sb.size(), 0);
    push(EV_TRESET);
    wait_treset("thresh_treset", 3000, cyc);

    // Stuck high for 3000 cycles.
    push(EV_STUCK);
    din = 1'b1;
    repeat (3000) @(negedge clk);
    chk("stuck_queue_drained", sb.size(), 0);
    chk("stuck_bit_count", int'(bit_count), 0);
    push(EV_TRESET);
    din = 1'b0;
    wait_treset("stuck_treset", 3000, cyc);
    chk("stuck_no_frame", int'(frame_active), 0);

    // Rise lands on the same cycle the low counter reaches T_RESET_CYC.
    push(EV_SHIFT1);
    send_pulse(40, 2500);
    push(EV_TRESET);
    send_pulse(40, 60);
    exp_count = 0;
    chk("race_queue_drained", sb.size(), 0);
    chk("race_bit_count", int'(bit_count), 0);
    chk("race_frame_active", int'(frame_active), 0);
    push(EV_SHIFT0);
    send_pulse(20, 42);
    chk("race_next_bit_count", int'(bit_count), exp_count);
    chk("race_next_frame_active", int'(frame_active), 1);

    // Reset asserted mid-bit.
    din = 1'b1;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_shift_reg", int'(sr), 0);
    chk("midreset_bit_count", int'(bit_count), 0);
    chk("midreset_frame_active", int'(frame_active), 0);
    exp_count = 0;
    last_bit  = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    din = 1'b0;
    repeat (30) @(negedge clk);
    din = 1'b1;
    repeat (40) @(negedge clk);
    push(EV_TRESET);
    din = 1'b0;
    wait_treset("midreset_treset", 3000, cyc);
    chk_range("midreset_latency", cyc, 2501, 2505);
    push(EV_SHIFT1);
    send_pulse(40, 22);
    chk("midreset_bit_count_after", int'(bit_count), exp_count);
    chk("midreset_frame_after", int'(frame_active), 1);
    chk("final_queue_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
